// File: rtl/imm_gen_if.sv
// Decode-stage immediate generator bus: instruction in, extended immediate out.
// Optional out_illegal exists only when IMM_ILLEGAL_CHK_EN is defined.
interface imm_gen_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
);
   // Handshake: a side holding valid keeps its payload stable until the beat
   // where valid && ready are both high at a rising clk edge; that edge is the transfer.
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_instr;
   logic [2:0]        in_imm_src;
   logic [TAG_W-1:0]  in_tag;
   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   out_imm;
   logic [2:0]        out_fmt;
   logic [TAG_W-1:0]  out_tag;
`ifdef IMM_ILLEGAL_CHK_EN
   logic              out_illegal;

   modport master (
      output in_valid, in_instr, in_imm_src, in_tag, out_ready,
      input  in_ready, out_valid, out_imm, out_fmt, out_tag, out_illegal
   );
   modport slave (
      input  in_valid, in_instr, in_imm_src, in_tag, out_ready,
      output in_ready, out_valid, out_imm, out_fmt, out_tag, out_illegal
   );
`else
   modport master (
      output in_valid, in_instr, in_imm_src, in_tag, out_ready,
      input  in_ready, out_valid, out_imm, out_fmt, out_tag
   );
   modport slave (
      input  in_valid, in_instr, in_imm_src, in_tag, out_ready,
      output in_ready, out_valid, out_imm, out_fmt, out_tag
   );
`endif
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with a 2-entry output skid buffer.
// Optional illegal-format flag enabled by defining IMM_ILLEGAL_CHK_EN.
module imm_gen_pipe #(
   parameter int XLEN            = 32,
   parameter int TAG_W           = 32,
   parameter int FMT_FROM_OPCODE = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   imm_gen_if.slave   bus,
   output logic [1:0] dbg_state
);
   localparam logic [2:0] FMT_I    = 3'b000;
   localparam logic [2:0] FMT_S    = 3'b001;
   localparam logic [2:0] FMT_B    = 3'b010;
   localparam logic [2:0] FMT_J    = 3'b011;
   localparam logic [2:0] FMT_U    = 3'b100;
   localparam logic [2:0] FMT_Z    = 3'b101;
   localparam logic [2:0] FMT_NONE = 3'b110;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   function automatic logic [2:0] decode_fmt(input logic [31:0] instr);
      logic [2:0] f;
      f = FMT_NONE;
      case (instr[6:0])
         7'b0010011, 7'b0000011, 7'b1100111: f = FMT_I;
         7'b1110011:                         f = instr[14] ? FMT_Z : FMT_I;
         7'b0100011:                         f = FMT_S;
         7'b1100011:                         f = FMT_B;
         7'b1101111:                         f = FMT_J;
         7'b0110111, 7'b0010111:             f = FMT_U;
         7'b0011011:                         f = (XLEN == 64) ? FMT_I : FMT_NONE;
         default:                            f = FMT_NONE;
      endcase
      return f;
   endfunction

   // Built at 64 bits and truncated so XLEN=32 needs no zero-width replication.
   function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] instr, input logic [2:0] fmt);
      logic [63:0] ext;
      logic [31:0] s32;
      s32 = {32{instr[31]}};
      case (fmt)
         FMT_I:   ext = {s32, {20{instr[31]}}, instr[31:20]};
         FMT_S:   ext = {s32, {20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B:   ext = {s32, {20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
         FMT_J:   ext = {s32, {12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
         FMT_U:   ext = {s32, instr[31:12], 12'b0};
         FMT_Z:   ext = {59'b0, instr[19:15]};
         default: ext = 64'b0;
      endcase
      return ext[XLEN-1:0];
   endfunction

   state_t           state;
   logic             in_rdy_q;
   logic             out_vld_q;
   logic [XLEN-1:0]  out_imm_q;
   logic [2:0]       out_fmt_q;
   logic [TAG_W-1:0] out_tag_q;
   logic [XLEN-1:0]  sk_imm;
   logic [2:0]       sk_fmt;
   logic [TAG_W-1:0] sk_tag;

   logic [2:0]       dec_fmt;
   logic [2:0]       sel_fmt;
   logic [XLEN-1:0]  new_imm;
   logic             in_xfer;
   logic             out_xfer;

   always_comb begin
      dec_fmt  = decode_fmt(bus.in_instr);
      sel_fmt  = (FMT_FROM_OPCODE != 0) ? dec_fmt : bus.in_imm_src;
      new_imm  = gen_imm(bus.in_instr, sel_fmt);
      in_xfer  = bus.in_valid && in_rdy_q;
      out_xfer = out_vld_q && bus.out_ready;
   end

`ifdef IMM_ILLEGAL_CHK_EN
   logic out_ill_q;
   logic sk_ill;
   logic new_ill;

   always_comb begin
      new_ill = (sel_fmt[2:1] == 2'b11) || (bus.in_instr[1:0] != 2'b11) ||
                ((FMT_FROM_OPCODE == 0) && (bus.in_imm_src != dec_fmt));
   end

   assign bus.out_illegal = out_ill_q;
`endif

   // in_ready is a register so it never combinationally follows out_ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_EMPTY;
         in_rdy_q  <= 1'b1;
         out_vld_q <= 1'b0;
         out_imm_q <= '0;
         out_fmt_q <= FMT_NONE;
         out_tag_q <= '0;
         sk_imm    <= '0;
         sk_fmt    <= FMT_NONE;
         sk_tag    <= '0;
`ifdef IMM_ILLEGAL_CHK_EN
         out_ill_q <= 1'b0;
         sk_ill    <= 1'b0;
`endif
      end else if (flush) begin
         state     <= ST_EMPTY;
         in_rdy_q  <= 1'b1;
         out_vld_q <= 1'b0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (in_xfer) begin
                  out_imm_q <= new_imm;
                  out_fmt_q <= sel_fmt;
                  out_tag_q <= bus.in_tag;
`ifdef IMM_ILLEGAL_CHK_EN
                  out_ill_q <= new_ill;
`endif
                  out_vld_q <= 1'b1;
                  state     <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (in_xfer && !out_xfer) begin
                  sk_imm   <= new_imm;
                  sk_fmt   <= sel_fmt;
                  sk_tag   <= bus.in_tag;
`ifdef IMM_ILLEGAL_CHK_EN
                  sk_ill   <= new_ill;
`endif
                  in_rdy_q <= 1'b0;
                  state    <= ST_TWO;
               end else if (in_xfer) begin
                  out_imm_q <= new_imm;
                  out_fmt_q <= sel_fmt;
                  out_tag_q <= bus.in_tag;
`ifdef IMM_ILLEGAL_CHK_EN
                  out_ill_q <= new_ill;
`endif
               end else if (out_xfer) begin
                  out_vld_q <= 1'b0;
                  state     <= ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (out_xfer) begin
                  out_imm_q <= sk_imm;
                  out_fmt_q <= sk_fmt;
                  out_tag_q <= sk_tag;
`ifdef IMM_ILLEGAL_CHK_EN
                  out_ill_q <= sk_ill;
`endif
                  in_rdy_q  <= 1'b1;
                  state     <= ST_ONE;
               end
            end
            default: begin
               state     <= ST_EMPTY;
               in_rdy_q  <= 1'b1;
               out_vld_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_rdy_q;
   assign bus.out_valid = out_vld_q;
   assign bus.out_imm   = out_imm_q;
   assign bus.out_fmt   = out_fmt_q;
   assign bus.out_tag   = out_tag_q;
   assign dbg_state     = state;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: two instances (XLEN=32 with imm_src, XLEN=64 with opcode decode)
// share one stimulus stream; results are checked against a queue-based reference model.
module tb_imm_gen_pipe;
   localparam int TAG_W = 32;
   localparam int W     = 100;  // {illegal, fmt, tag, imm[63:0]}

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic [1:0] dbg_a;
   logic [1:0] dbg_b;

   imm_gen_if #(.XLEN(32), .TAG_W(TAG_W)) bus_a ();
   imm_gen_if #(.XLEN(64), .TAG_W(TAG_W)) bus_b ();

   imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W), .FMT_FROM_OPCODE(0)) dut_a (
      .clk(clk), .rst(rst), .flush(flush), .bus(bus_a), .dbg_state(dbg_a)
   );
   imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W), .FMT_FROM_OPCODE(1)) dut_b (
      .clk(clk), .rst(rst), .flush(flush), .bus(bus_b), .dbg_state(dbg_b)
   );

   // clock / reset
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [W-1:0] exp_a[$];
   logic [W-1:0] exp_b[$];
   int delivered[$];

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // reference model
   function automatic logic [2:0] m_decode(input logic [31:0] ins, input int xlen);
      case (ins[6:0])
         7'h13, 7'h03, 7'h67: return 3'd0;
         7'h73:               return ins[14] ? 3'd5 : 3'd0;
         7'h23:               return 3'd1;
         7'h63:               return 3'd2;
         7'h6F:               return 3'd3;
         7'h37, 7'h17:        return 3'd4;
         7'h1B:               return (xlen == 64) ? 3'd0 : 3'd6;
         default:             return 3'd6;
      endcase
   endfunction

   function automatic longint m_imm(input logic [31:0] ins, input logic [2:0] fmt);
      longint u;
      longint sg;
      u  = longint'({32'b0, ins});
      sg = ins[31] ? 64'sd1 : 64'sd0;
      case (fmt)
         3'd0: return ((u >> 20) & 4095) - sg * 4096;
         3'd1: return ((u >> 25) & 127) * 32 + ((u >> 7) & 31) - sg * 4096;
         3'd2: return ((u >> 7) & 1) * 2048 + ((u >> 25) & 63) * 32 + ((u >> 8) & 15) * 2 - sg * 4096;
         3'd3: return ((u >> 12) & 255) * 4096 + ((u >> 20) & 1) * 2048 + ((u >> 21) & 1023) * 2
                      - sg * 1048576;
         3'd4: return (u & 64'sh0000_0000_FFFF_F000) - sg * 64'sh1_0000_0000;
         3'd5: return (u >> 15) & 31;
         default: return 0;
      endcase
   endfunction

   function automatic logic [W-1:0] m_result(input logic [31:0] ins, input logic [2:0] src,
                                             input logic [31:0] tag, input bit from_op, input int xlen);
      logic [2:0]  fmt;
      logic [63:0] r;
      logic        ill;
      fmt = from_op ? m_decode(ins, xlen) : src;
      r   = 64'(m_imm(ins, fmt));
      if (xlen == 32) r[63:32] = 32'b0;
      ill = 1'b0;
`ifdef IMM_ILLEGAL_CHK_EN
      ill = (fmt >= 3'd6) || (ins[1:0] != 2'b11) || (!from_op && (src != m_decode(ins, xlen)));
`endif
      return {ill, fmt, tag, r};
   endfunction

   function automatic logic [W-1:0] obs_a();
      logic ill;
      ill = 1'b0;
`ifdef IMM_ILLEGAL_CHK_EN
      ill = bus_a.out_illegal;
`endif
      return {ill, bus_a.out_fmt, bus_a.out_tag, 32'b0, bus_a.out_imm};
   endfunction

   function automatic logic [W-1:0] obs_b();
      logic ill;
      ill = 1'b0;
`ifdef IMM_ILLEGAL_CHK_EN
      ill = bus_b.out_illegal;
`endif
      return {ill, bus_b.out_fmt, bus_b.out_tag, bus_b.out_imm};
   endfunction

   task automatic check_outputs();
      check("a_in_ready",  128'(bus_a.in_ready),  128'(exp_a.size() < 2));
      check("b_in_ready",  128'(bus_b.in_ready),  128'(exp_b.size() < 2));
      check("a_out_valid", 128'(bus_a.out_valid), 128'(exp_a.size() > 0));
      check("b_out_valid", 128'(bus_b.out_valid), 128'(exp_b.size() > 0));
      if (exp_a.size() > 0) check("a_result", 128'(obs_a()), 128'(exp_a[0]));
      if (exp_b.size() > 0) check("b_result", 128'(obs_b()), 128'(exp_b[0]));
   endtask

   // driver: one clock cycle of stimulus, model update, then settle just after the edge
   task automatic step(input logic v, input logic [31:0] ins, input logic [2:0] src,
                       input logic [31:0] tag, input logic rdy, input logic fl);
      bit in_x;
      bit out_x;
      @(negedge clk);
      check_outputs();
      bus_a.in_valid = v;   bus_b.in_valid = v;
      bus_a.in_instr = ins; bus_b.in_instr = ins;
      bus_a.in_imm_src = src; bus_b.in_imm_src = src;
      bus_a.in_tag = tag;   bus_b.in_tag = tag;
      bus_a.out_ready = rdy; bus_b.out_ready = rdy;
      flush = fl;
      in_x  = v && (exp_a.size() < 2);
      out_x = rdy && (exp_a.size() > 0);
      if (fl) begin
         exp_a.delete();
         exp_b.delete();
      end else begin
         if (bus_a.out_valid && rdy) delivered.push_back(int'(bus_a.out_tag));
         if (out_x) begin
            void'(exp_a.pop_front());
            void'(exp_b.pop_front());
         end
         if (in_x) begin
            exp_a.push_back(m_result(ins, src, tag, 1'b0, 32));
            exp_b.push_back(m_result(ins, src, tag, 1'b1, 64));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus_a.in_valid = 1'b1;  bus_b.in_valid = 1'b1;
      bus_a.out_ready = 1'b1; bus_b.out_ready = 1'b1;
      flush = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      bus_a.in_valid = 1'b0;  bus_b.in_valid = 1'b0;
      exp_a.delete();
      exp_b.delete();
   endtask

   logic [6:0] ops [13] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h6F,
                            7'h37, 7'h17, 7'h1B, 7'h33, 7'h00, 7'h7F};

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      bus_a.in_valid = 1'b0;  bus_b.in_valid = 1'b0;
      bus_a.in_instr = '0;    bus_b.in_instr = '0;
      bus_a.in_imm_src = '0;  bus_b.in_imm_src = '0;
      bus_a.in_tag = '0;      bus_b.in_tag = '0;
      bus_a.out_ready = 1'b0; bus_b.out_ready = 1'b0;

      do_reset();
      check("rst_out_valid", 128'(bus_a.out_valid), 128'(0));
      check("rst_out_imm",   128'(bus_a.out_imm),   128'(0));
      check("rst_out_fmt",   128'(bus_a.out_fmt),   128'(3'b110));
      check("rst_out_tag",   128'(bus_a.out_tag),   128'(0));
      check("rst_in_ready",  128'(bus_a.in_ready),  128'(1));
      check("rst_b_imm",     128'(bus_b.out_imm),   128'(0));

      // directed formats
      step(1'b1, 32'hFFF00093, 3'b000, 32'd10, 1'b1, 1'b0);
      check("i_valid", 128'(bus_a.out_valid), 128'(1));
      check("i_imm_a", 128'(bus_a.out_imm), 128'(32'hFFFF_FFFF));
      check("i_imm_b", 128'(bus_b.out_imm), 128'(64'hFFFF_FFFF_FFFF_FFFF));
      step(1'b1, 32'hFE112E23, 3'b001, 32'd11, 1'b1, 1'b0);
      check("s_imm_a", 128'(bus_a.out_imm), 128'(32'hFFFF_FFFC));
      step(1'b1, 32'hFE000CE3, 3'b010, 32'd12, 1'b1, 1'b0);
      check("b_imm_a", 128'(bus_a.out_imm), 128'(32'hFFFF_FFF8));
      step(1'b1, 32'h001000EF, 3'b011, 32'd13, 1'b1, 1'b0);
      check("j_fmt_b", 128'(bus_b.out_fmt), 128'(3'b011));
      check("j_imm_b", 128'(bus_b.out_imm), 128'(64'h800));
      step(1'b1, 32'h123450B7, 3'b100, 32'd14, 1'b1, 1'b0);
      check("u_fmt_b", 128'(bus_b.out_fmt), 128'(3'b100));
      check("u_imm_b", 128'(bus_b.out_imm), 128'(64'h1234_5000));
`ifdef IMM_ILLEGAL_CHK_EN
      step(1'b1, 32'h00000000, 3'b000, 32'd15, 1'b1, 1'b0);
      check("ill_zero_a", 128'(bus_a.out_illegal), 128'(1));
      check("ill_zero_imm", 128'(bus_a.out_imm), 128'(0));
      check("ill_zero_b", 128'(bus_b.out_illegal), 128'(1));
      step(1'b1, 32'hFFF00093, 3'b000, 32'd16, 1'b1, 1'b0);
      check("ill_addi_a", 128'(bus_a.out_illegal), 128'(0));
      check("ill_addi_b", 128'(bus_b.out_illegal), 128'(0));
`endif
      step(1'b0, 32'h0, 3'b000, 32'd0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 3'b000, 32'd0, 1'b1, 1'b0);

      // backpressure: tags 1..4 with the consumer stalled, then released
      delivered.delete();
      step(1'b1, 32'hFFF00093, 3'b000, 32'd1, 1'b0, 1'b0);
      step(1'b1, 32'hFFF00093, 3'b000, 32'd2, 1'b0, 1'b0);
      check("bp_in_ready", 128'(bus_a.in_ready), 128'(0));
      check("bp_tag_hold", 128'(bus_a.out_tag), 128'(1));
      step(1'b1, 32'hFFF00093, 3'b000, 32'd3, 1'b0, 1'b0);
      check("bp_tag_hold2", 128'(bus_a.out_tag), 128'(1));
      step(1'b1, 32'hFFF00093, 3'b000, 32'd3, 1'b1, 1'b0);
      step(1'b1, 32'hFFF00093, 3'b000, 32'd3, 1'b1, 1'b0);
      step(1'b1, 32'hFFF00093, 3'b000, 32'd4, 1'b1, 1'b0);
      step(1'b0, 32'h0, 3'b000, 32'd0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 3'b000, 32'd0, 1'b1, 1'b0);
      check("bp_count", 128'(delivered.size()), 128'(4));
      for (int i = 0; i < delivered.size(); i++)
         check("bp_order", 128'(delivered[i]), 128'(i + 1));

      // flush while full, with a same-cycle input
      delivered.delete();
      step(1'b1, 32'hFE112E23, 3'b001, 32'd20, 1'b0, 1'b0);
      step(1'b1, 32'hFE112E23, 3'b001, 32'd21, 1'b0, 1'b0);
      step(1'b1, 32'hFE112E23, 3'b001, 32'd22, 1'b0, 1'b1);
      check("fl_out_valid", 128'(bus_a.out_valid), 128'(0));
      check("fl_in_ready",  128'(bus_a.in_ready),  128'(1));
      check("fl_tag_hold",  128'(bus_a.out_tag),   128'(20));
      repeat (3) step(1'b0, 32'h0, 3'b000, 32'd0, 1'b1, 1'b0);
      check("fl_no_leak", 128'(delivered.size()), 128'(0));

      // reset while full
      step(1'b1, 32'h123450B7, 3'b100, 32'd30, 1'b0, 1'b0);
      step(1'b1, 32'h123450B7, 3'b100, 32'd31, 1'b0, 1'b0);
      delivered.delete();
      do_reset();
      check("rr_out_valid", 128'(bus_a.out_valid), 128'(0));
      check("rr_in_ready",  128'(bus_a.in_ready),  128'(1));
      repeat (2) step(1'b0, 32'h0, 3'b000, 32'd0, 1'b1, 1'b0);
      check("rr_no_leak", 128'(delivered.size()), 128'(0));

      // randomized traffic
      repeat (800) begin
         logic [31:0] ins;
         ins = $urandom();
         if ($urandom_range(0, 4) != 0) ins[6:0] = ops[$urandom_range(0, 12)];
         step(1'($urandom_range(0, 3) != 0), ins, 3'($urandom_range(0, 7)), $urandom(),
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
      end
      repeat (3) step(1'b0, 32'h0, 3'b000, 32'd0, 1'b1, 1'b0);
      @(negedge clk);
      check_outputs();

      // report
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
